// File: rtl/mixer_cnt_sched.sv
// Mixer phase counter scheduler: arms on enable, starts/retunes on datapath sync, delays sync_out.
// Optional macro MIXER_CNT_SCHED_SYNC_CNT_EN adds a saturating sync_out pulse counter (sync_count).
module mixer_cnt_sched #(
  parameter int CNT_W    = 10,
  parameter int SYNC_LAT = 2
) (
  input  logic             user_clk,
  input  logic             user_rst_n,
  input  logic [31:0]      cfg_data,
  input  logic             sync_in,
  output logic [CNT_W-1:0] phase_out,
  output logic             phase_vld,
  output logic             sync_out,
  output logic             cfg_pending,
  output logic [1:0]       state_out
`ifdef MIXER_CNT_SCHED_SYNC_CNT_EN
  ,
  output logic [15:0]      sync_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    BAD   = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [31:0]       cfg_q;
  logic [CNT_W:0]    cfg_prev;
  logic [CNT_W-1:0]  shadow_step, active_step, phase_next;
  logic [SYNC_LAT-1:0] sync_dly, sync_dly_next;
  logic              enable, cfg_change, accept, vld_next;
  logic              cfg_unused;

  assign enable     = cfg_q[31];
  assign cfg_change = ({cfg_q[30], cfg_q[CNT_W-1:0]} != cfg_prev);
  assign cfg_unused = ^cfg_q[29:CNT_W];
  assign state_out  = state;
  assign sync_out   = sync_dly[SYNC_LAT-1];

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    phase_next = phase_out;
    vld_next   = phase_vld;
    case (state)
      IDLE: begin
        phase_next = '0;
        vld_next   = 1'b0;
        if (enable) state_next = ARMED;
      end
      ARMED: begin
        if (sync_in) begin
          accept     = 1'b1;
          phase_next = '0;
          vld_next   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        phase_next = phase_out + active_step;
        // A change detected this very cycle must wait for the following sync
        if (sync_in && cfg_pending && !cfg_change) begin
          accept     = 1'b1;
          phase_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
        vld_next   = 1'b0;
      end
    endcase
    if (!enable) begin
      state_next = IDLE;
      accept     = 1'b0;
      phase_next = '0;
      vld_next   = 1'b0;
    end
  end

  always_comb begin
    sync_dly_next[0] = accept;
    for (int i = 1; i < SYNC_LAT; i++) sync_dly_next[i] = sync_dly[i-1];
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      cfg_q       <= '0;
      cfg_prev    <= '0;
      shadow_step <= '0;
      active_step <= '0;
      cfg_pending <= 1'b0;
      phase_out   <= '0;
      phase_vld   <= 1'b0;
      sync_dly    <= '0;
    end else begin
      cfg_q    <= cfg_data;
      cfg_prev <= {cfg_q[30], cfg_q[CNT_W-1:0]};
      if (cfg_change) shadow_step <= cfg_q[CNT_W-1:0];
      if (accept)     active_step <= shadow_step;
      if (cfg_change)  cfg_pending <= 1'b1;
      else if (accept) cfg_pending <= 1'b0;
      phase_out <= phase_next;
      phase_vld <= vld_next;
      // Disabling drops every sync pulse still in flight
      sync_dly  <= enable ? sync_dly_next : '0;
    end
  end

`ifdef MIXER_CNT_SCHED_SYNC_CNT_EN
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)                         sync_count <= '0;
    else if (state_next == IDLE)             sync_count <= '0;
    else if (sync_out && sync_count != 16'hFFFF) sync_count <= sync_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mixer_cnt_sched.sv
// Bench for mixer_cnt_sched: fixed vector table, hand-written corner sequences and a randomized
// run compared every cycle with a queue-based reference model.
module tb_mixer_cnt_sched;
  localparam int CNT_W    = 10;
  localparam int SYNC_LAT = 2;

  logic             user_clk = 1'b0;
  logic             user_rst_n = 1'b0;
  logic [31:0]      cfg_data = '0;
  logic             sync_in = 1'b0;
  logic [CNT_W-1:0] phase_out;
  logic             phase_vld, sync_out, cfg_pending;
  logic [1:0]       state_out;
`ifdef MIXER_CNT_SCHED_SYNC_CNT_EN
  logic [15:0]      sync_count;
`endif

  mixer_cnt_sched #(.CNT_W(CNT_W), .SYNC_LAT(SYNC_LAT)) dut (
    .user_clk(user_clk),
    .user_rst_n(user_rst_n),
    .cfg_data(cfg_data),
    .sync_in(sync_in),
    .phase_out(phase_out),
    .phase_vld(phase_vld),
    .sync_out(sync_out),
    .cfg_pending(cfg_pending),
    .state_out(state_out)
`ifdef MIXER_CNT_SCHED_SYNC_CNT_EN
    ,
    .sync_count(sync_count)
`endif
  );

  always #5 user_clk = ~user_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec rules applied per clock edge, sync pulses kept as due-edge numbers
  int          m_state, m_edge, m_cnt, m_phase, m_shadow, m_active;
  bit          m_vld, m_pend, m_sync;
  logic [31:0] m_cfgq, m_cfgprev;
  int          m_due[$];

  function automatic void model_reset();
    m_state = 0; m_phase = 0; m_shadow = 0; m_active = 0; m_cnt = 0;
    m_vld = 0; m_pend = 0; m_sync = 0; m_cfgq = '0; m_cfgprev = '0;
    m_due.delete();
  endfunction

  function automatic void model_edge(input logic [31:0] cfg, input bit sin);
    bit en, det, acc;
    int ns, np, na;
    bit nv;
    m_edge++;
    en  = m_cfgq[31];
    det = (m_cfgq[30] != m_cfgprev[30]) ||
          ((m_cfgq % (1 << CNT_W)) != (m_cfgprev % (1 << CNT_W)));
    acc = 0; ns = m_state; np = m_phase; nv = m_vld; na = m_active;
    if (!en) begin
      ns = 0; np = 0; nv = 0; m_due.delete();
    end else if (m_state == 0) begin
      ns = 1;
    end else if (m_state == 1) begin
      if (sin) begin acc = 1; ns = 2; np = 0; nv = 1; na = m_shadow; end
    end else begin
      np = (m_phase + m_active) % (1 << CNT_W);
      if (sin && m_pend && !det) begin acc = 1; np = 0; na = m_shadow; end
    end
    if (ns == 0) m_cnt = 0;
    else if (m_sync && m_cnt < 65535) m_cnt++;
    if (det) m_pend = 1;
    else if (acc) m_pend = 0;
    if (det) m_shadow = int'(m_cfgq % (1 << CNT_W));
    if (acc) m_due.push_back(m_edge + SYNC_LAT - 1);
    while (m_due.size() > 0 && m_due[0] < m_edge) void'(m_due.pop_front());
    m_sync = (m_due.size() > 0 && m_due[0] == m_edge);
    m_cfgprev = m_cfgq; m_cfgq = cfg;
    m_state = ns; m_phase = np; m_vld = nv; m_active = na;
  endfunction

  task automatic compare_model();
    check("state", state_out, m_state);
    check("phase", phase_out, m_phase);
    check("vld", phase_vld, m_vld);
    check("sync_out", sync_out, m_sync);
    check("pending", cfg_pending, m_pend);
`ifdef MIXER_CNT_SCHED_SYNC_CNT_EN
    check("sync_count", sync_count, m_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge user_clk);
    if (user_rst_n) model_edge(cfg_data, sync_in);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [31:0] cfg;
    logic        sync;
    int          st;
    int          ph;
    logic        vld;
    logic        so;
    logic        pd;
  } vec_t;
  vec_t tbl[17];

  initial begin
    int sync_seen;
    tbl[0]  = '{32'h8000_0003, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{32'h8000_0003, 0, 1,  0, 0, 0, 1};
    tbl[2]  = '{32'h8000_0003, 0, 1,  0, 0, 0, 1};
    tbl[3]  = '{32'h8000_0003, 1, 2,  0, 1, 0, 0};
    tbl[4]  = '{32'h8000_0003, 0, 2,  3, 1, 1, 0};
    tbl[5]  = '{32'h8000_0003, 0, 2,  6, 1, 0, 0};
    tbl[6]  = '{32'h8000_0003, 0, 2,  9, 1, 0, 0};
    tbl[7]  = '{32'h8000_0005, 0, 2, 12, 1, 0, 0};
    tbl[8]  = '{32'h8000_0005, 0, 2, 15, 1, 0, 1};
    tbl[9]  = '{32'h8000_0005, 1, 2,  0, 1, 0, 0};
    tbl[10] = '{32'h8000_0005, 0, 2,  5, 1, 1, 0};
    tbl[11] = '{32'h8000_0005, 0, 2, 10, 1, 0, 0};
    tbl[12] = '{32'h8000_0007, 0, 2, 15, 1, 0, 0};
    tbl[13] = '{32'h8000_0007, 1, 2, 20, 1, 0, 1};
    tbl[14] = '{32'h8000_0007, 0, 2, 25, 1, 0, 1};
    tbl[15] = '{32'h8000_0007, 1, 2,  0, 1, 0, 0};
    tbl[16] = '{32'h8000_0007, 0, 2,  7, 1, 1, 0};

    model_reset();
    m_edge = 0;
    #3;
    check("rst_state", state_out, 0);
    check("rst_phase", phase_out, 0);
    check("rst_vld", phase_vld, 0);
    check("rst_sync", sync_out, 0);
    check("rst_pend", cfg_pending, 0);
    repeat (2) @(posedge user_clk);
    #3 user_rst_n = 1'b1;

    // Start-up, retune and simultaneous change/sync
    for (int i = 0; i < 17; i++) begin
      cfg_data = tbl[i].cfg;
      sync_in  = tbl[i].sync;
      tick();
      check($sformatf("tbl%0d_state", i), state_out, tbl[i].st);
      check($sformatf("tbl%0d_phase", i), phase_out, tbl[i].ph);
      check($sformatf("tbl%0d_vld", i), phase_vld, tbl[i].vld);
      check($sformatf("tbl%0d_sync", i), sync_out, tbl[i].so);
      check($sformatf("tbl%0d_pend", i), cfg_pending, tbl[i].pd);
    end
    sync_in = 0;
    tick();

    // Step 0 holds phase constant while valid
    cfg_data = 32'h8000_0000;
    repeat (2) tick();
    sync_in = 1; tick(); sync_in = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("step0_phase", phase_out, 0);
      check("step0_vld", phase_vld, 1);
    end

    // Step 3 across the 2^CNT_W wrap
    cfg_data = 32'h8000_0003;
    repeat (2) tick();
    sync_in = 1; tick(); sync_in = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      check("wrap_phase", phase_out, (3 * k) % 1024);
    end

    // Randomized configuration and sync traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
          0: w[9:0] = '0;
          1: w[9:0] = 10'h3FF;
          default: ;
        endcase
        w[31] = ($urandom_range(0, 9) != 0);
        cfg_data = w;
      end
      sync_in = ($urandom_range(0, 5) == 0);
      tick();
    end
    sync_in = 0;

    // Disable with a sync_out still in flight
    cfg_data = 32'h8000_0011;
    repeat (3) tick();
    sync_in = 1; tick(); sync_in = 0;
    repeat (3) tick();
    cfg_data = 32'h8000_0012;
    repeat (2) tick();
    check("dis_pend", cfg_pending, 1);
    sync_in = 1; cfg_data = 32'h0000_0012;
    tick();
    sync_in = 0;
    sync_seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (sync_out) sync_seen++;
      if (k == 2) begin
        check("dis_state", state_out, 0);
        check("dis_vld", phase_vld, 0);
      end
    end
    check("dis_sync_suppressed", sync_seen, 0);

    // Asynchronous reset mid-RUN with a pending change
    cfg_data = 32'h8000_0004;
    repeat (3) tick();
    sync_in = 1; tick(); sync_in = 0;
    repeat (3) tick();
    cfg_data = 32'h8000_0009;
    repeat (2) tick();
    check("pre_rst_pend", cfg_pending, 1);
    #2 user_rst_n = 1'b0;
    cfg_data = '0;
    #1;
    check("arst_state", state_out, 0);
    check("arst_phase", phase_out, 0);
    check("arst_vld", phase_vld, 0);
    check("arst_sync", sync_out, 0);
    check("arst_pend", cfg_pending, 0);
    model_reset();
    tick();
    #2 user_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sync_in = (k % 2 == 0);
      tick();
    end
    sync_in = 0;
    check("post_rst_idle", state_out, 0);
    cfg_data = 32'h8000_0006;
    repeat (3) tick();
    sync_in = 1; tick(); sync_in = 0;
    repeat (4) tick();
    check("rearm_state", state_out, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
